// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared IO bus FSM state type, bus widths and RW encoding.
package io_bus_pkg;
    typedef enum logic [1:0] {IDLE, STROBE, RELEASE, DONE} io_bus_state_t;
    localparam int IO_BUS_DATA_W = 32;
    localparam int IO_BUS_ADDR_W = 8;
    localparam logic IO_BUS_READ = 1'b1;
    localparam logic IO_BUS_WRITE = 1'b0;
endpackage

// File: rtl/io_bus_master_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first set req bit strictly after last_grant.
// Ports: req (request vector), last_grant (index served last), grant (one-hot), valid (any request).
module rr_arbiter
    import io_bus_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       valid
);
    // Walk distances from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        grant = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req[j] && j == (int'(last_grant) + i) % NUM_REQ) begin
                    grant = '0;
                    grant[j] = 1'b1;
                end
            end
        end
    end
    assign valid = |req;
endmodule

// File: rtl/io_bus_master_arbiter.sv
// io_bus_master_arbiter: round-robin sharing of the IO bus between requesters, running the
// handshake_1/handshake_2 four-phase protocol and returning ack/rdata/err to the winner.
// Ports: clk, reset (async, active-high); req/req_rw/req_addr/req_wdata per requester;
// ack (one-cycle pulse), rdata, err, busy; bus_* drive/receive the IO_bus master side.
// Optional watchdog: define IO_BUS_TIMEOUT_EN to abort stuck handshakes after TIMEOUT_CYCLES.
module io_bus_master_arbiter
    import io_bus_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0]                req_rw,
    input  logic [NUM_REQ*IO_BUS_ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*IO_BUS_DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                ack,
    output logic [IO_BUS_DATA_W-1:0]          rdata,
    output logic                              err,
    output logic                              busy,
    output logic [IO_BUS_DATA_W-1:0]          bus_data_out,
    output logic [IO_BUS_ADDR_W-1:0]          bus_reg_address,
    output logic                              bus_RW,
    output logic                              bus_handshake_1,
    input  logic [IO_BUS_DATA_W-1:0]          bus_data_in,
    input  logic                              bus_handshake_2
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("io_bus_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    io_bus_state_t             state_q, state_d;
    logic [IDX_W-1:0]          gidx_q, gidx_d, last_q, last_d, sel_idx;
    logic [NUM_REQ-1:0]        ack_q, ack_d, grant;
    logic [IO_BUS_DATA_W-1:0]  rdata_q, rdata_d, data_q, data_d;
    logic [IO_BUS_ADDR_W-1:0]  addr_q, addr_d;
    logic                      rw_q, rw_d, hs1_q, hs1_d, valid, timeout;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req),
        .last_grant (last_q),
        .grant      (grant),
        .valid      (valid)
    );

    always_comb begin
        sel_idx = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant[j]) sel_idx = IDX_W'(j);
        end
    end

`ifdef IO_BUS_TIMEOUT_EN
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = (TW < 8) ? 8 : ((TW > 16) ? 16 : TW);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d, err_q, err_d;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign err     = err_q;

    // Counter is held at zero in IDLE, so it starts from zero on entry to STROBE.
    // to_q remembers that the current transaction was aborted rather than completed.
    always_comb begin
        cnt_d = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
        to_d  = to_q;
        if (state_q == IDLE)
            to_d = 1'b0;
        else if (state_q == STROBE && timeout && !bus_handshake_2)
            to_d = 1'b1;
        else if (state_q == RELEASE && timeout && bus_handshake_2)
            to_d = 1'b1;
        err_d = (state_q == DONE) && to_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        data_d  = data_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        hs1_d   = hs1_q;
        case (state_q)
            IDLE: begin
                // Skip the ack cycle so a requester still holding req is not granted twice.
                if (valid && ack_q == '0) begin
                    gidx_d  = sel_idx;
                    rw_d    = req_rw[sel_idx];
                    addr_d  = req_addr[sel_idx*IO_BUS_ADDR_W +: IO_BUS_ADDR_W];
                    data_d  = req_wdata[sel_idx*IO_BUS_DATA_W +: IO_BUS_DATA_W];
                    hs1_d   = 1'b1;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (bus_handshake_2) begin
                    if (rw_q == IO_BUS_READ) rdata_d = bus_data_in;
                    hs1_d   = 1'b0;
                    state_d = RELEASE;
                end else if (timeout) begin
                    hs1_d   = 1'b0;
                    state_d = DONE;
                end
            end
            RELEASE: begin
                if (!bus_handshake_2 || timeout) state_d = DONE;
            end
            DONE: begin
                ack_d[gidx_q] = 1'b1;
                last_d        = gidx_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            ack_q   <= '0;
            rdata_q <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            hs1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            hs1_q   <= hs1_d;
        end
    end

    assign ack             = ack_q;
    assign rdata           = rdata_q;
    assign busy            = (state_q != IDLE);
    assign bus_data_out    = data_q;
    assign bus_reg_address = addr_q;
    assign bus_RW          = rw_q;
    assign bus_handshake_1 = hs1_q;
endmodule

// File: tb/tb_io_bus_master_arbiter.sv
// tb_io_bus_master_arbiter: randomized scoreboard bench with a behavioural round-robin/bus model.
module tb_io_bus_master_arbiter;
    localparam int NR = 3;
`ifdef IO_BUS_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 255;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req = '0, req_rw = '0;
    logic [NR*8-1:0] req_addr = '0;
    logic [NR*32-1:0] req_wdata = '0;
    logic [NR-1:0]   ack;
    logic [31:0]     rdata, bus_data_out;
    logic            err, busy, bus_RW, bus_handshake_1;
    logic [7:0]      bus_reg_address;
    logic [31:0]     bus_data_in = '0;
    logic            bus_handshake_2 = 1'b0;

    io_bus_master_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_rw          (req_rw),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .ack             (ack),
        .rdata           (rdata),
        .err             (err),
        .busy            (busy),
        .bus_data_out    (bus_data_out),
        .bus_reg_address (bus_reg_address),
        .bus_RW          (bus_RW),
        .bus_handshake_1 (bus_handshake_1),
        .bus_data_in     (bus_data_in),
        .bus_handshake_2 (bus_handshake_2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          ack_at;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0, n_fail = 0, cyc = 0, last_ack = -100, m_last = NR - 1;
    logic [31:0] m_rdata = '0;
    int          fix_d1 = -1, fix_d2 = -1;
    logic        force_mute = 1'b0, use_fix_data = 1'b0;
    logic [31:0] fix_data = '0;
    int          p_cnt[NR], p_app[NR];
    logic        p_rw[NR];
    logic [7:0]  p_addr[NR];
    logic [31:0] p_wd[NR];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic post(input int i, input logic rw, input logic [7:0] a, input logic [31:0] d);
        p_rw[i] = rw;
        p_addr[i] = a;
        p_wd[i] = d;
        p_cnt[i]++;
    endtask

    function automatic logic pending();
        logic r;
        r = 1'b0;
        for (int i = 0; i < NR; i++) if (p_cnt[i] != p_app[i]) r = 1'b1;
        return r;
    endfunction

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while ((req != '0 || pending() || q.size() != 0 || busy) && t < 600) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk({"idle_", nm}, 64'(t < 600), 1);
    endtask

    // Requesters and slave: model prediction is made when a new strobe appears.
    initial begin : driver
        logic        p_hs1, mute;
        int          ph, c1, c2, w;
        logic [31:0] sd;
        exp_t        e;
        p_hs1 = 1'b0; mute = 1'b0; ph = 0; c1 = 0; c2 = 0; sd = '0; w = 0;
        for (int i = 0; i < NR; i++) begin p_cnt[i] = 0; p_app[i] = 0; end
        forever begin
            @(negedge clk);
            cyc++;
            if (!bus_handshake_2) bus_data_in = $urandom;
            if (reset) begin
                req = '0;
                bus_handshake_2 = 1'b0;
                ph = 0;
                p_hs1 = 1'b0;
                q.delete();
                m_last = NR - 1;
                m_rdata = '0;
                for (int i = 0; i < NR; i++) p_app[i] = p_cnt[i];
            end else begin
                if (bus_handshake_1 && !p_hs1) begin
                    w = -1;
                    for (int k = 1; k <= NR; k++)
                        if (w < 0 && req[(m_last + k) % NR]) w = (m_last + k) % NR;
                    chk("grant_has_request", 64'(w >= 0), 1);
                    if (w < 0) w = 0;
                    m_last = w;
                    mute = force_mute;
`ifdef IO_BUS_TIMEOUT_EN
                    if (fix_d1 < 0 && $urandom_range(0, 7) == 0) mute = 1'b1;
`endif
                    c1 = (fix_d1 >= 0) ? fix_d1 : int'($urandom_range(0, 3));
                    c2 = (fix_d2 >= 0) ? fix_d2 : int'($urandom_range(0, 2));
                    sd = use_fix_data ? fix_data : $urandom;
                    e.idx = w;
                    e.rw = req_rw[w];
                    e.addr = req_addr[w*8 +: 8];
                    e.wdata = req_wdata[w*32 +: 32];
                    if (!mute && e.rw) m_rdata = sd;
                    e.rdata = m_rdata;
                    e.err = mute;
                    e.ack_at = mute ? cyc + TO + 2 : cyc + 3 + c1 + c2;
                    q.push_back(e);
                    ph = 1;
                end
                if (ph == 1 && !mute) begin
                    if (c1 == 0) begin
                        bus_handshake_2 = 1'b1;
                        bus_data_in = sd;
                        ph = 2;
                    end else c1--;
                end else if (ph == 2 && !bus_handshake_1) begin
                    if (c2 == 0) begin
                        bus_handshake_2 = 1'b0;
                        ph = 0;
                    end else c2--;
                end
                for (int i = 0; i < NR; i++) if (ack[i]) begin req[i] = 1'b0; ph = 0; end
                for (int i = 0; i < NR; i++) begin
                    if (p_cnt[i] != p_app[i] && !req[i]) begin
                        req_rw[i] = p_rw[i];
                        req_addr[i*8 +: 8] = p_addr[i];
                        req_wdata[i*32 +: 32] = p_wd[i];
                        req[i] = 1'b1;
                        p_app[i] = p_cnt[i];
                    end
                end
                p_hs1 = bus_handshake_1;
            end
        end
    end

    initial begin : monitor
        logic          p1, p2;
        logic [NR-1:0] ev;
        exp_t          e;
        p1 = 1'b0; p2 = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (bus_handshake_1 && !p1) chk("grant_gap", 64'(cyc - last_ack >= 2), 1);
            if (p1 && p2) chk("hs1_fall_after_hs2", 64'(bus_handshake_1), 0);
            if (bus_handshake_1) begin
                if (q.size() == 0) chk("strobe_without_grant", 0, 1);
                else begin
                    chk("bus_fields", {bus_RW, bus_reg_address, bus_data_out},
                        {q[0].rw, q[0].addr, q[0].wdata});
                    chk("busy", 64'(busy), 1);
                end
            end
            if (ack != '0) begin
                if (q.size() == 0) chk("spurious_ack", 64'(ack), 0);
                else begin
                    e = q.pop_front();
                    ev = '0;
                    ev[e.idx] = 1'b1;
                    chk("ack_vec", 64'(ack), 64'(ev));
                    chk("rdata", 64'(rdata), 64'(e.rdata));
                    chk("err", 64'(err), 64'(e.err));
                    chk("ack_time", 64'(cyc), 64'(e.ack_at));
                    last_ack = cyc;
                end
            end
            p1 = bus_handshake_1;
            p2 = bus_handshake_2;
        end
    end

    initial begin : main
        repeat (3) @(negedge clk);
        #2;
        chk("reset_rdata", 64'(rdata), 0);
        chk("reset_bus", {bus_reg_address, bus_data_out}, 0);
        chk("reset_ctl", {ack, err, busy, bus_RW, bus_handshake_1}, 0);
        reset = 1'b0;

        fix_d1 = 0; fix_d2 = 0;
        post(0, 1'b0, 8'h12, 32'hDEADBEEF);
        wait_idle("write");

        fix_d1 = 3; use_fix_data = 1'b1; fix_data = 32'h0000ABCD;
        post(1, 1'b1, 8'h05, $urandom);
        wait_idle("read");
        chk("read_rdata_hold", 64'(rdata), 64'h0000ABCD);

        fix_d1 = -1; fix_d2 = -1; use_fix_data = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #2;
            for (int i = 0; i < 2; i++)
                if (!req[i] && p_cnt[i] == p_app[i]) post(i, 1'($urandom), 8'($urandom), $urandom);
        end
        wait_idle("contention");

`ifdef IO_BUS_TIMEOUT_EN
        force_mute = 1'b1; fix_d1 = 0; fix_d2 = 0;
        post(0, 1'b1, 8'h33, $urandom);
        wait_idle("timeout");
        force_mute = 1'b0; fix_d1 = -1; fix_d2 = -1;
`endif

        force_mute = 1'b1;
        post(1, 1'b1, 8'h44, $urandom);
        for (int t = 0; t < 50 && !bus_handshake_1; t++) begin
            @(negedge clk);
            #2;
        end
        chk("strobe_before_reset", 64'(bus_handshake_1), 1);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_rdata", 64'(rdata), 0);
        chk("midreset_bus", {bus_reg_address, bus_data_out}, 0);
        chk("midreset_ctl", {ack, err, busy, bus_RW, bus_handshake_1}, 0);
        force_mute = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #2;
            chk("reset_no_ack", 64'(ack), 0);
        end
        reset = 1'b0;
        post(1, 1'b0, 8'h55, $urandom);
        post(0, 1'b0, 8'h66, $urandom);
        wait_idle("after_reset");

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            #2;
            for (int i = 0; i < NR; i++)
                if (!req[i] && p_cnt[i] == p_app[i] && $urandom_range(0, 3) == 0)
                    post(i, 1'($urandom), 8'($urandom), $urandom);
        end
        wait_idle("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
